seq_digit_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, generalising the team's fixed 2-bit full adder to WIDTH bits. Processes DIGIT bits per clock, LSB digit first, through an internal DIGIT-bit ripple full-adder slice. Uses a start/busy/done handshake. Sits between switch/register inputs and the seven-segment/LED result registers on the FPGA board designs.

---
 rtl/seq_digit_adder.sv | 172 +++++++++++++++++
 tb/tb_seq_digit_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_digit_adder.sv
// rtl/seq_digit_adder.sv - multi-cycle digit-serial adder/subtractor with start/busy/done handshake
//
// Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, LSB digit
// first, through a DIGIT-bit ripple full-adder slice.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request an operation (sampled only while idle)
//   sub    - 0: a + b + cin, 1: a - b
//   a, b   - operands (WIDTH bits)
//   cin    - carry-in for add mode
//   busy   - operation in progress
//   done   - one-cycle pulse when sum/cout/ovf update
//   sum    - registered result (modulo 2^WIDTH)
//   cout   - carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    - signed overflow

module seq_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Digit slice: ripple through DIGIT full adders. slice_cmsb is the carry
    // into the slice's top bit, which on the last digit is the carry into the
    // operand MSB needed for signed overflow.
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    always_comb begin
        logic cc;
        cc         = carry_q;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                slice_cmsb = cc;
            end
            slice_sum[i] = opa_q[i] ^ opb_q[i] ^ cc;
            cc           = (opa_q[i] & opb_q[i]) | (cc & (opa_q[i] ^ opb_q[i]));
        end
        slice_cout = cc;
    end

    // Result digits enter at the top of the accumulator; after N shifts the
    // first (least significant) digit has reached bit 0.
    logic [WIDTH-1:0] acc_shift;
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    // Subtraction is a + ~b + 1.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = acc_shift;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_digit_adder.sv
// tb/tb_seq_digit_adder.sv - self-checking bench for seq_digit_adder over several WIDTH/DIGIT pairs

module tb_seq_digit_adder;

    localparam int NI = 5;

    logic clk;
    logic rst_n;

    logic        start_v [NI];
    logic        sub_v   [NI];
    logic [15:0] a_v     [NI];
    logic [15:0] b_v     [NI];
    logic        cin_v   [NI];
    logic        busy_v  [NI];
    logic        done_v  [NI];
    logic [15:0] sum_v   [NI];
    logic        cout_v  [NI];
    logic        ovf_v   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0 is (8,2); instances 1..4 are the sweep (8,1), (8,8), (16,4), (2,1).
    function automatic int wk(input int k);
        return (k == 3) ? 16 : (k == 4) ? 2 : 8;
    endfunction

    function automatic int dk(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 8 : (k == 3) ? 4 : 1;
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int W = (k == 3) ? 16 : (k == 4) ? 2 : 8;
        localparam int D = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 8 : (k == 3) ? 4 : 1;
        logic [W-1:0] s;
        logic         bz, dn, co, ov;

        seq_digit_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[k]),
            .sub   (sub_v[k]),
            .a     (a_v[k][W-1:0]),
            .b     (b_v[k][W-1:0]),
            .cin   (cin_v[k]),
            .busy  (bz),
            .done  (dn),
            .sum   (s),
            .cout  (co),
            .ovf   (ov)
        );

        assign sum_v[k]  = 16'(s);
        assign busy_v[k] = bz;
        assign done_v[k] = dn;
        assign cout_v[k] = co;
        assign ovf_v[k]  = ov;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract and signed range test.
    task automatic model(input int w, input logic s, input longint ua, input longint ub,
                         input logic c, output longint es, output logic eco, output logic eov);
        longint m, full, sa, sb, r, smax, smin;
        m    = (longint'(1) << w) - 1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = (ua > smax) ? ua - (m + 1) : ua;
        sb   = (ub > smax) ? ub - (m + 1) : ub;
        if (!s) begin
            full = ua + ub + longint'(c);
            eco  = (full > m);
            r    = sa + sb + longint'(c);
        end else begin
            full = ua - ub;
            eco  = (ua >= ub);
            r    = sa - sb;
        end
        es  = full & m;
        eov = (r > smax) || (r < smin);
    endtask

    task automatic run_op(input int k, input logic s, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, output logic [15:0] so, output logic co, output logic vo,
                          output int lat, output int bcnt, output logic dafter);
        @(negedge clk);
        sub_v[k]   = s;
        a_v[k]     = av;
        b_v[k]     = bv;
        cin_v[k]   = c;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k]     = ~av;
        b_v[k]     = ~bv;
        cin_v[k]   = ~c;
        sub_v[k]   = ~s;
        lat  = 0;
        bcnt = 0;
        while (!done_v[k] && lat < 64) begin
            if (busy_v[k]) bcnt++;
            @(negedge clk);
            lat++;
        end
        so = sum_v[k];
        co = cout_v[k];
        vo = ovf_v[k];
        @(negedge clk);
        dafter = done_v[k];
    endtask

    task automatic directed(input string tag, input logic s, input logic [15:0] av, input logic [15:0] bv,
                            input logic c, input logic [15:0] es, input logic eco, input logic eov);
        logic [15:0] so;
        logic        co, vo, da;
        int          lat, bc;
        run_op(0, s, av, bv, c, so, co, vo, lat, bc, da);
        check({tag, " sum"}, 32'(so), 32'(es));
        check({tag, " cout"}, 32'(co), 32'(eco));
        check({tag, " ovf"}, 32'(vo), 32'(eov));
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " busy cycles"}, 32'(bc), 32'd4);
        check({tag, " done width"}, 32'(da), 32'd0);
    endtask

    initial begin
        logic [15:0] so;
        logic        co, vo, da;
        int          lat, bc, dcnt, n;
        logic [15:0] got;
        longint      es, m;
        logic        eco, eov, s;
        logic [15:0] ra, rb;
        logic        rc;

        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0;
            sub_v[k]   = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
            cin_v[k]   = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy_v[0]), 32'd0);
        check("reset done", 32'(done_v[0]), 32'd0);
        check("reset sum", 32'(sum_v[0]), 32'd0);
        check("reset cout", 32'(cout_v[0]), 32'd0);
        check("reset ovf", 32'(ovf_v[0]), 32'd0);
        rst_n = 1'b1;

        directed("add 7f+01", 1'b0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1);
        directed("add ff+00+1", 1'b0, 16'hFF, 16'h00, 1'b1, 16'h00, 1'b1, 1'b0);
        directed("add 3c+45", 1'b0, 16'h3C, 16'h45, 1'b0, 16'h81, 1'b0, 1'b1);
        directed("sub 05-07", 1'b1, 16'h05, 16'h07, 1'b1, 16'hFE, 1'b0, 1'b0);
        directed("sub 80-01", 1'b1, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b1, 1'b1);
        directed("sub 10-10", 1'b1, 16'h10, 16'h10, 1'b0, 16'h00, 1'b1, 1'b0);

        // Start while busy is ignored: only 0x01+0x01 is reported, once.
        @(negedge clk);
        sub_v[0] = 1'b0; cin_v[0] = 1'b0; a_v[0] = 16'h01; b_v[0] = 16'h01; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        a_v[0] = 16'hF0; b_v[0] = 16'h0F; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        dcnt = 0;
        got  = '0;
        repeat (14) begin
            @(negedge clk);
            if (done_v[0]) begin
                dcnt++;
                got = sum_v[0];
            end
        end
        check("busy-start done count", 32'(dcnt), 32'd1);
        check("busy-start sum", 32'(got), 32'h02);

        // Start on the done cycle is ignored; the following idle cycle accepts it.
        @(negedge clk);
        a_v[0] = 16'h20; b_v[0] = 16'h02; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (!done_v[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("pre-op latency", 32'(n), 32'd4);
        a_v[0] = 16'h11; b_v[0] = 16'h11; start_v[0] = 1'b1;
        @(negedge clk);
        check("start on done ignored", 32'(busy_v[0]), 32'd0);
        a_v[0] = 16'h30; b_v[0] = 16'h03;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("idle start accepted", 32'(busy_v[0]), 32'd1);
        n = 0;
        while (!done_v[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("after-done latency", 32'(n), 32'd4);
        check("after-done sum", 32'(sum_v[0]), 32'h33);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        @(negedge clk);
        a_v[0] = 16'h12; b_v[0] = 16'h34; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("pre-reset busy", 32'(busy_v[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy_v[0]), 32'd0);
        check("async reset done", 32'(done_v[0]), 32'd0);
        check("async reset sum", 32'(sum_v[0]), 32'd0);
        check("async reset cout", 32'(cout_v[0]), 32'd0);
        check("async reset ovf", 32'(ovf_v[0]), 32'd0);
        #9 rst_n = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        check("no done after reset", 32'(dcnt), 32'd0);
        directed("post-reset add", 1'b0, 16'h0A, 16'h05, 1'b1, 16'h10, 1'b0, 1'b0);

        // Random sweep against the arithmetic model.
        for (int k = 1; k < NI; k++) begin
            m = (longint'(1) << wk(k)) - 1;
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom) & 16'(m);
                rb = 16'($urandom) & 16'(m);
                rc = 1'($urandom);
                s  = 1'($urandom);
                model(wk(k), s, longint'(ra), longint'(rb), rc, es, eco, eov);
                run_op(k, s, ra, rb, rc, so, co, vo, lat, bc, da);
                check($sformatf("sweep%0d sum %h%s%h", k, ra, s ? "-" : "+", rb), 32'(so), 32'(es));
                check($sformatf("sweep%0d cout", k), 32'(co), 32'(eco));
                check($sformatf("sweep%0d ovf", k), 32'(vo), 32'(eov));
                check($sformatf("sweep%0d latency", k), 32'(lat), 32'(wk(k) / dk(k)));
                check($sformatf("sweep%0d done width", k), 32'(da), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
